// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the memory port arbiter.
// Imported by mem_arb_prio and mem_port_arbiter.
package mem_arb_pkg;

   typedef enum logic {IDLE, RD} arb_state_t;
   typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

   localparam int STARVE_MAX_DEF = 4;
   localparam int LATENCY_DEF    = 1;
   localparam int STARVE_W       = $clog2(STARVE_MAX_DEF + 1);
   localparam int LAT_W          = $clog2(LATENCY_DEF + 1);

   // Width of a counter that must hold values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals of the arbiter.
// master is the arbiter's view; slave is the view of the core and RAM.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_rw, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_rw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and load/store, D first, with a
// saturating starve counter that forces IF after STARVE_MAX D wins.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic d_req,
   input  logic allow,
   output logic gnt_if,
   output logic gnt_d
);
   localparam int SW = cnt_w(STARVE_MAX);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve;

   always_comb begin
      gnt_d  = allow & d_req & ~(if_req & (starve == SMAX));
      gnt_if = allow & if_req & ~gnt_d;
   end

   // Only D wins made while IF is waiting count toward starvation.
   always_ff @(posedge clk) begin
      if (reset || !if_req || gnt_if)
         starve <= '0;
      else if (gnt_d && starve != SMAX)
         starve <= starve + SW'(1);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch (IF) and load/store (D), one access in flight.
// Define MEM_ARB_PERF_CNT_EN to add the perf_if_wait/perf_d_wait wait-cycle counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.master  bus
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_if_wait,
   output logic [31:0]         perf_d_wait
`endif
);
   localparam int LW = cnt_w(LATENCY);
   localparam logic [LW-1:0] LMAX = LW'(LATENCY);

   arb_state_t    state, state_nxt;
   arb_owner_t    owner, owner_nxt;
   logic [LW-1:0] wcnt, wcnt_nxt;
   logic          rd_done;
   logic          allow;
   logic          gnt_if, gnt_d;

   assign allow = (state == IDLE) & ~reset;

   mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk    (clk),
      .reset  (reset),
      .if_req (bus.if_req),
      .d_req  (bus.d_req),
      .allow  (allow),
      .gnt_if (gnt_if),
      .gnt_d  (gnt_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         owner <= OWN_IF;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // Stores complete in the grant cycle; only reads occupy the port afterwards.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      wcnt_nxt  = wcnt;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_d && !bus.d_we) begin
               state_nxt = RD;
               owner_nxt = OWN_D;
               wcnt_nxt  = LMAX;
            end else if (gnt_if) begin
               state_nxt = RD;
               owner_nxt = OWN_IF;
               wcnt_nxt  = LMAX;
            end
         end
         RD: begin
            if (wcnt == LW'(1)) begin
               rd_done   = ~reset;
               state_nxt = IDLE;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt - LW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.if_gnt    = gnt_if;
   assign bus.d_gnt     = gnt_d;
   assign bus.mem_en    = gnt_if | gnt_d;
   assign bus.mem_rw    = gnt_d & bus.d_we;
   assign bus.mem_addr  = gnt_d ? bus.d_addr : (gnt_if ? bus.if_addr : '0);
   assign bus.mem_wdata = gnt_d ? bus.d_wdata : '0;

   assign bus.if_rvalid = rd_done & (owner == OWN_IF);
   assign bus.d_rvalid  = rd_done & (owner == OWN_D);
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
   assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_if_wait <= '0;
         perf_d_wait  <= '0;
      end else begin
         if (bus.if_req && !gnt_if) perf_if_wait <= perf_if_wait + 32'd1;
         if (bus.d_req  && !gnt_d)  perf_d_wait  <= perf_d_wait  + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level timing model.
module tb_mem_port_arbiter;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_if_wait;
   logic [31:0] perf_d_wait;
`endif

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .perf_if_wait (perf_if_wait),
      .perf_d_wait  (perf_d_wait)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   function automatic logic [133:0] outs();
      return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
              bus.d_rdata, bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drain();
      next_cycle();
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      repeat (LAT + 1) next_cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_wdata = 32'h5;
      bus.mem_rdata = 32'hA5A5_A5A5;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         settle();
         checks++;
         if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs());
         end
      end
      next_cycle();
      reset = 1'b0;
      settle();
      checks++;
      if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_grant: got d/if=%b want 10", {bus.d_gnt, bus.if_gnt});
      end
      drain();
   endtask

   task automatic test_load();
      next_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
      bus.if_req = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
      settle();
      checks++;
      if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_rw} !== 4'b1010 ||
          bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL load_grant: got gnt/en/rw=%b addr=%h wdata=%h want 1010 40 1234",
                  {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_rw}, bus.mem_addr, bus.mem_wdata);
      end
      next_cycle();
      bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h200;
      settle();
      checks++;
      if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.d_rvalid} !== 4'b0000 || bus.d_rdata !== '0) begin
         errors++;
         $display("FAIL load_wait: got gnt/en/rv=%b rdata=%h want 0000 0",
                  {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.d_rvalid}, bus.d_rdata);
      end
      next_cycle();
      settle();
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF ||
          bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL load_data: got rv=%b rdata=%h gnt=%b want 1 deadbeef 00",
                  bus.d_rvalid, bus.d_rdata, {bus.if_gnt, bus.d_gnt});
      end
      next_cycle();
      settle();
      checks++;
      if (bus.if_gnt !== 1'b1 || bus.mem_rw !== 1'b0 || bus.mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL load_then_fetch: got if_gnt=%b rw=%b addr=%h want 1 0 200",
                  bus.if_gnt, bus.mem_rw, bus.mem_addr);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [2];
      logic [31:0] datas [2];
      addrs[0] = 32'h10; addrs[1] = 32'h14;
      datas[0] = 32'h1111; datas[1] = 32'h2222;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = addrs[i]; bus.d_wdata = datas[i];
         settle();
         checks++;
         if ({bus.mem_en, bus.mem_rw, bus.d_gnt, bus.d_rvalid, bus.if_rvalid} !== 5'b11100 ||
             bus.mem_addr !== addrs[i] || bus.mem_wdata !== datas[i]) begin
            errors++;
            $display("FAIL store_b2b %0d: got en/rw/gnt/rv=%b addr=%h wdata=%h want 11100 %h %h", i,
                     {bus.mem_en, bus.mem_rw, bus.d_gnt, bus.d_rvalid, bus.if_rvalid},
                     bus.mem_addr, bus.mem_wdata, addrs[i], datas[i]);
         end
      end
      for (int i = 0; i < LAT + 1; i++) begin
         next_cycle();
         bus.d_req = 1'b0;
         settle();
         checks++;
         if ({bus.mem_en, bus.d_rvalid, bus.if_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL store_no_rvalid %0d: got en/rv=%b want 000", i,
                     {bus.mem_en, bus.d_rvalid, bus.if_rvalid});
         end
      end
   endtask

   task automatic test_starvation();
      int n = 0;
      int budget = 0;
      logic exp_if;
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h50; bus.d_wdata = 32'h77;
      settle();
      while (n < 10 && budget < 200) begin
         if (bus.d_gnt || bus.if_gnt) begin
            exp_if = (n % 5 == 4);
            checks++;
            if ({bus.if_gnt, bus.d_gnt} !== {exp_if, ~exp_if} ||
                bus.mem_rw !== ~exp_if || bus.mem_addr !== (exp_if ? 32'h300 : 32'h50)) begin
               errors++;
               $display("FAIL starve_grant %0d: got if/d=%b rw=%b addr=%h want %b %b %h", n,
                        {bus.if_gnt, bus.d_gnt}, bus.mem_rw, bus.mem_addr,
                        {exp_if, ~exp_if}, ~exp_if, exp_if ? 32'h300 : 32'h50);
            end
            n++;
         end
         budget++;
         if (n < 10) begin
            next_cycle();
            settle();
         end
      end
      checks++;
      if (n < 10) begin
         errors++;
         $display("FAIL starve_timeout: got %0d grants want 10", n);
      end
      drain();
   endtask

   task automatic test_reset_mid_read();
      next_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h60; bus.if_req = 1'b0;
      bus.mem_rdata = 32'hCAFE_F00D;
      settle();
      checks++;
      if (bus.d_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midrd_grant: got d_gnt=%b want 1", bus.d_gnt);
      end
      next_cycle();
      bus.d_req = 1'b0; reset = 1'b1;
      settle();
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL midrd_reset_outputs: got %h want 0", outs());
      end
      next_cycle();
      reset = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h400;
      settle();
      checks++;
      if (bus.d_rvalid !== 1'b0 || bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h400) begin
         errors++;
         $display("FAIL midrd_idle: got d_rv=%b if_gnt=%b addr=%h want 0 1 400",
                  bus.d_rvalid, bus.if_gnt, bus.mem_addr);
      end
      for (int i = 0; i < LAT + 1; i++) begin
         next_cycle();
         bus.if_req = 1'b0;
         settle();
         checks++;
         if (bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrd_dropped %0d: got d_rvalid=%b want 0", i, bus.d_rvalid);
         end
      end
   endtask

   // Model: the port is free from cycle free_at; a read granted in cycle c
   // returns in c+LAT and frees the port at c+LAT+1.
   task automatic test_random();
      int cyc = 0, free_at = 0, starve = 0, rv_at = -1;
      bit rv_d = 1'b0, ig_prev = 1'b0, dg_prev = 1'b0;
      bit gd, gi;
      logic [133:0] exp_v;
      logic [31:0] e_addr, e_wdata, e_ird, e_drd;
      bit e_irv, e_drv;
      for (int k = 0; k < 600; k++) begin
         next_cycle();
         if (!bus.if_req || ig_prev) begin
            bus.if_req  = ($urandom_range(0, 99) < 55);
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!bus.d_req || dg_prev) begin
            bus.d_req   = ($urandom_range(0, 99) < 60);
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom & 32'hFFFF_FFFC;
            bus.d_wdata = $urandom;
         end
         bus.mem_rdata = $urandom;
         settle();
         gd = (cyc >= free_at) && bus.d_req && !(bus.if_req && starve == SMAX);
         gi = (cyc >= free_at) && bus.if_req && !gd;
         e_addr  = gd ? bus.d_addr : (gi ? bus.if_addr : 32'h0);
         e_wdata = gd ? bus.d_wdata : 32'h0;
         e_irv   = (rv_at == cyc) && !rv_d;
         e_drv   = (rv_at == cyc) && rv_d;
         e_ird   = e_irv ? bus.mem_rdata : 32'h0;
         e_drd   = e_drv ? bus.mem_rdata : 32'h0;
         exp_v = {gi, e_irv, e_ird, gd, e_drv, e_drd, (gd | gi), (gd & bus.d_we), e_addr, e_wdata};
         checks++;
         if (outs() !== exp_v) begin
            errors++;
            $display("FAIL random cycle %0d: got %h want %h", cyc, outs(), exp_v);
         end
         if (gd) begin
            if (bus.d_we) free_at = cyc + 1;
            else begin free_at = cyc + LAT + 1; rv_at = cyc + LAT; rv_d = 1'b1; end
         end
         if (gi) begin free_at = cyc + LAT + 1; rv_at = cyc + LAT; rv_d = 1'b0; end
         if (!bus.if_req || gi) starve = 0;
         else if (gd && starve < SMAX) starve++;
         ig_prev = gi;
         dg_prev = gd;
         cyc++;
      end
      drain();
   endtask

`ifdef MEM_ARB_PERF_CNT_EN
   task automatic test_perf();
      next_cycle();
      reset = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0;
      settle();
      next_cycle();
      reset = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h70;
      settle();
      next_cycle();
      bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h500;
      settle();
      next_cycle();
      settle();
      next_cycle();
      bus.d_req = 1'b1;
      settle();
      next_cycle();
      bus.d_req = 1'b0;
      settle();
      next_cycle();
      settle();
      next_cycle();
      settle();
      checks++;
      if (bus.if_gnt !== 1'b1 || perf_if_wait !== 32'd5 || perf_d_wait !== 32'd0) begin
         errors++;
         $display("FAIL perf_wait: got if_gnt=%b if_wait=%0d d_wait=%0d want 1 5 0",
                  bus.if_gnt, perf_if_wait, perf_d_wait);
      end
      drain();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0;
      test_reset();
      test_load();
      test_back_to_back();
      test_starvation();
      test_reset_mid_read();
      test_random();
`ifdef MEM_ARB_PERF_CNT_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
